// File: rtl/adc_share_arbiter.sv
// adc_share_arbiter: shares one soc/eoc A/D converter among three dav_/rfd consumers in round-robin order.
// Optional eoc-wait timeout with sticky err output is enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_share_arbiter #(
    parameter int W = 8
`ifdef ADC_ARB_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [W-1:0] x,
    input  logic         eoc,
    output logic         soc,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    input  logic         rfd1,
    input  logic         rfd2,
    input  logic         rfd3,
    output logic         dav1_,
    output logic         dav2_,
    output logic         dav3_
`ifdef ADC_ARB_TIMEOUT_EN
    ,output logic        err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SOC, S_CONV, S_DAV} state_t;

    state_t       r_state, w_state_nxt;
    logic [1:0]   r_ptr, w_ptr_nxt;
    logic [1:0]   r_win, w_win_nxt;
    logic         r_soc, w_soc_nxt;
    logic [2:0]   r_dav_n, w_dav_n_nxt;
    logic [W-1:0] r_d [3];
    logic         w_cap;
    logic [2:0]   w_rfd;
    logic         w_any;
    logic [1:0]   w_pick;
    logic [1:0]   w_c1, w_c2;

`ifdef ADC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_err, w_err_nxt;
    logic          w_tmo;
    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign w_rfd = {rfd3, rfd2, rfd1};
    assign w_c1  = inc3(r_ptr);
    assign w_c2  = inc3(w_c1);

    // First requester at or after the pointer, wrapping 3 -> 1.
    always_comb begin
        w_any  = 1'b1;
        w_pick = r_ptr;
        if (w_rfd[r_ptr])     w_pick = r_ptr;
        else if (w_rfd[w_c1]) w_pick = w_c1;
        else if (w_rfd[w_c2]) w_pick = w_c2;
        else                  w_any  = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_soc_nxt   = r_soc;
        w_dav_n_nxt = r_dav_n;
        w_cap       = 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
        w_err_nxt   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any && eoc) begin
                    w_win_nxt   = w_pick;
                    w_soc_nxt   = 1'b1;
                    w_state_nxt = S_SOC;
                end
            end
            S_SOC: begin
                if (!eoc) begin
                    w_soc_nxt   = 1'b0;
                    w_state_nxt = S_CONV;
                end
`ifdef ADC_ARB_TIMEOUT_EN
                else if (w_tmo) begin
                    w_soc_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_ptr_nxt   = inc3(r_win);
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_CONV: begin
                if (eoc) begin
                    w_cap                = 1'b1;
                    w_dav_n_nxt[r_win]   = 1'b0;
                    w_state_nxt          = S_DAV;
                end
`ifdef ADC_ARB_TIMEOUT_EN
                else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_ptr_nxt   = inc3(r_win);
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_DAV: begin
                // A winner that already withdrew releases on the first DAV cycle.
                if (!w_rfd[r_win]) begin
                    w_dav_n_nxt[r_win] = 1'b1;
                    w_ptr_nxt          = inc3(r_win);
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            r_soc   <= 1'b0;
            r_dav_n <= 3'b111;
            for (int i = 0; i < 3; i++) r_d[i] <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_soc   <= w_soc_nxt;
            r_dav_n <= w_dav_n_nxt;
            if (w_cap) r_d[r_win] <= x;
`ifdef ADC_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign soc   = r_soc;
    assign d1    = r_d[0];
    assign d2    = r_d[1];
    assign d3    = r_d[2];
    assign dav1_ = r_dav_n[0];
    assign dav2_ = r_dav_n[1];
    assign dav3_ = r_dav_n[2];
`ifdef ADC_ARB_TIMEOUT_EN
    assign err   = r_err;
`endif

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Bench for adc_share_arbiter: directed vector table, hand-written reset/timeout sequences, and
// randomized traffic checked against a transaction-level round-robin model (ADC_ARB_TIMEOUT_EN adds timeout test).
module tb_adc_share_arbiter;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clock = 1'b0;
    logic         reset_;
    logic [W-1:0] x;
    logic         eoc;
    logic         soc;
    logic [W-1:0] d1, d2, d3;
    logic         rfd1, rfd2, rfd3;
    logic         dav1_, dav2_, dav3_;
    logic [2:0]   dav_n;
`ifdef ADC_ARB_TIMEOUT_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign dav_n = {dav3_, dav2_, dav1_};

    always #5 clock = ~clock;

    adc_share_arbiter #(
        .W(W)
`ifdef ADC_ARB_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clock(clock), .reset_(reset_), .x(x), .eoc(eoc), .soc(soc),
        .d1(d1), .d2(d2), .d3(d3),
        .rfd1(rfd1), .rfd2(rfd2), .rfd3(rfd3),
        .dav1_(dav1_), .dav2_(dav2_), .dav3_(dav3_)
`ifdef ADC_ARB_TIMEOUT_EN
        ,.err(err)
`endif
    );

    typedef struct packed {
        logic [2:0] rfd;
        logic       eoc;
        logic [7:0] x;
        logic       e_soc;
        logic [2:0] e_dav_n;
        logic [7:0] e_d1;
        logic [7:0] e_d2;
        logic [7:0] e_d3;
    } vec_t;
    vec_t tbl [25];

    // Transaction-level model state
    int         m_ptr;
    int         m_pend;
    int         wd;
    logic [7:0] m_d [3];
    logic [7:0] m_sample;
    logic       prev_soc;
    logic [2:0] prev_dav;
    int         grants [$];
    int         cv_phase, cv_cnt;
    int         cn_cnt [3];
    int         rr_idx;
    logic [7:0] rr_s [6] = '{8'h00, 8'h5C, 8'hAB, 8'h3F, 8'hC4, 8'h91};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] r, input logic e, input logic [7:0] xv);
        {rfd3, rfd2, rfd1} = r;
        eoc = e;
        x   = xv;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_pend = -1; wd = 0;
        for (int i = 0; i < 3; i++) begin m_d[i] = 8'h00; cn_cnt[i] = 0; end
        m_sample = 8'h00; cv_phase = 0; cv_cnt = 0; rr_idx = 0;
        prev_soc = soc; prev_dav = dav_n;
    endtask

    task automatic monitor();
        logic [2:0] r;
        r = {rfd3, rfd2, rfd1};
        if (soc && !prev_soc) begin
            m_pend = -1;
            for (int k = 0; k < 3; k++)
                if (m_pend < 0 && r[(m_ptr + k) % 3]) m_pend = (m_ptr + k) % 3;
            check("grant_has_request", 64'(m_pend >= 0), 64'(1));
            check("grant_eoc_idle", 64'(eoc), 64'(1));
            wd = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (!dav_n[i] && prev_dav[i]) begin
                check("dav_winner", 64'(i), 64'(m_pend));
                m_d[i] = m_sample;
                grants.push_back(i);
            end
            if (dav_n[i] && !prev_dav[i]) begin
                m_ptr  = (i + 1) % 3;
                m_pend = -1;
            end
        end
        check("d_regs", {40'h0, d1, d2, d3}, {40'h0, m_d[0], m_d[1], m_d[2]});
        check("one_dav", 64'($countones(~dav_n) <= 1), 64'(1));
        check("soc_dav_overlap", 64'(soc && (dav_n != 3'b111)), 64'(0));
        if (m_pend >= 0) begin
            wd++;
            if (wd > 200) begin
                n_checks++; n_fail++;
                $display("FAIL grant_watchdog: transaction pending %0d cycles, required <= 200", wd);
                m_pend = -1; wd = 0;
            end
        end
        prev_soc = soc;
        prev_dav = dav_n;
    endtask

    task automatic drive_models(input int mode);
        logic [2:0] r;
        r = {rfd3, rfd2, rfd1};
        for (int i = 0; i < 3; i++) begin
            if (mode == 1) begin
                if (!dav_n[i] && r[i]) begin
                    r[i] = 1'b0; cn_cnt[i] = i + 1;
                end else if (dav_n[i] && !r[i]) begin
                    cn_cnt[i]--;
                    if (cn_cnt[i] <= 0) r[i] = 1'b1;
                end
            end else begin
                if (!dav_n[i]) begin
                    if (r[i] && $urandom_range(0, 1) == 1) r[i] = 1'b0;
                end else if (!r[i]) begin
                    if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
                end else if ($urandom_range(0, 15) == 0) begin
                    r[i] = 1'b0;
                end
            end
        end
        {rfd3, rfd2, rfd1} = r;
        // Converter: drops eoc some cycles after soc, later returns a fresh sample with eoc=1.
        if (cv_phase == 0 && soc && eoc) begin
            cv_phase = 1; cv_cnt = $urandom_range(0, 2);
        end else if (cv_phase == 2) begin
            if (cv_cnt == 0) begin
                x = (mode == 1) ? rr_s[rr_idx % 6] : 8'($urandom);
                rr_idx++;
                m_sample = x; eoc = 1'b1; cv_phase = 0;
            end else cv_cnt--;
        end
        if (cv_phase == 1) begin
            if (cv_cnt == 0) begin
                eoc = 1'b0; cv_cnt = $urandom_range(0, 3); cv_phase = 2;
            end else cv_cnt--;
        end
    endtask

    task automatic run_auto(input int mode, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clock); #1;
            monitor();
            if (mode == 1 && grants.size() >= 6) break;
            drive_models(mode);
        end
    endtask

    task automatic pulse_reset();
        reset_ = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_ = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global time limit reached");
    end

    initial begin
        tbl[0]  = '{3'b000, 1'b1, 8'h00, 1'b0, 3'b111, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{3'b010, 1'b1, 8'h00, 1'b1, 3'b111, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{3'b010, 1'b1, 8'h00, 1'b1, 3'b111, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{3'b010, 1'b0, 8'h00, 1'b0, 3'b111, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{3'b010, 1'b0, 8'h00, 1'b0, 3'b111, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{3'b010, 1'b1, 8'hA5, 1'b0, 3'b101, 8'h00, 8'hA5, 8'h00};
        tbl[6]  = '{3'b010, 1'b1, 8'hA5, 1'b0, 3'b101, 8'h00, 8'hA5, 8'h00};
        tbl[7]  = '{3'b000, 1'b1, 8'hA5, 1'b0, 3'b111, 8'h00, 8'hA5, 8'h00};
        tbl[8]  = '{3'b001, 1'b0, 8'hA5, 1'b0, 3'b111, 8'h00, 8'hA5, 8'h00};
        tbl[9]  = '{3'b001, 1'b0, 8'hA5, 1'b0, 3'b111, 8'h00, 8'hA5, 8'h00};
        tbl[10] = '{3'b001, 1'b1, 8'hA5, 1'b1, 3'b111, 8'h00, 8'hA5, 8'h00};
        tbl[11] = '{3'b001, 1'b0, 8'hA5, 1'b0, 3'b111, 8'h00, 8'hA5, 8'h00};
        tbl[12] = '{3'b001, 1'b1, 8'h3C, 1'b0, 3'b110, 8'h3C, 8'hA5, 8'h00};
        tbl[13] = '{3'b000, 1'b1, 8'h3C, 1'b0, 3'b111, 8'h3C, 8'hA5, 8'h00};
        tbl[14] = '{3'b111, 1'b1, 8'h3C, 1'b1, 3'b111, 8'h3C, 8'hA5, 8'h00};
        tbl[15] = '{3'b111, 1'b0, 8'h3C, 1'b0, 3'b111, 8'h3C, 8'hA5, 8'h00};
        tbl[16] = '{3'b111, 1'b1, 8'h77, 1'b0, 3'b101, 8'h3C, 8'h77, 8'h00};
        tbl[17] = '{3'b101, 1'b1, 8'h77, 1'b0, 3'b111, 8'h3C, 8'h77, 8'h00};
        tbl[18] = '{3'b101, 1'b1, 8'h77, 1'b1, 3'b111, 8'h3C, 8'h77, 8'h00};
        tbl[19] = '{3'b101, 1'b0, 8'h77, 1'b0, 3'b111, 8'h3C, 8'h77, 8'h00};
        tbl[20] = '{3'b001, 1'b0, 8'h77, 1'b0, 3'b111, 8'h3C, 8'h77, 8'h00};
        tbl[21] = '{3'b001, 1'b1, 8'hE1, 1'b0, 3'b011, 8'h3C, 8'h77, 8'hE1};
        tbl[22] = '{3'b001, 1'b1, 8'hE1, 1'b0, 3'b111, 8'h3C, 8'h77, 8'hE1};
        tbl[23] = '{3'b100, 1'b1, 8'hE1, 1'b1, 3'b111, 8'h3C, 8'h77, 8'hE1};
        tbl[24] = '{3'b100, 1'b0, 8'hE1, 1'b0, 3'b111, 8'h3C, 8'h77, 8'hE1};

        reset_ = 1'b1;
        set_in(3'b000, 1'b1, 8'h00);
        #3 reset_ = 1'b0;
        #1 check("reset_state", {39'h0, soc, dav_n, d1, d2, d3}, {39'h0, 1'b0, 3'b111, 24'h0});
        repeat (3) @(posedge clock);
        #1 reset_ = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            check($sformatf("idle_cycle%0d", k), {59'h0, soc, dav_n, 1'(d1 != 0 || d2 != 0 || d3 != 0)},
                  {59'h0, 1'b0, 3'b111, 1'b0});
        end

        for (int i = 0; i < 25; i++) begin
            set_in(tbl[i].rfd, tbl[i].eoc, tbl[i].x);
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), {36'h0, soc, dav_n, d1, d2, d3},
                  {36'h0, tbl[i].e_soc, tbl[i].e_dav_n, tbl[i].e_d1, tbl[i].e_d2, tbl[i].e_d3});
        end

        // Asynchronous reset while consumer 3's conversion is in flight.
        reset_ = 1'b0;
        #1 check("reset_midconv", {36'h0, soc, dav_n, d1, d2, d3}, {36'h0, 1'b0, 3'b111, 24'h0});
        @(posedge clock); #1;
        reset_ = 1'b1;
        set_in(3'b111, 1'b1, 8'h00);
        @(posedge clock); #1;
        check("restart_soc", 64'(soc), 64'(1));
        eoc = 1'b0;
        @(posedge clock); #1;
        check("restart_conv", 64'(soc), 64'(0));
        set_in(3'b111, 1'b1, 8'h42);
        @(posedge clock); #1;
        check("restart_winner1", {53'h0, dav_n, d1}, {53'h0, 3'b110, 8'h42});
        set_in(3'b000, 1'b1, 8'h42);
        @(posedge clock); #1;
        check("restart_release", 64'(dav_n), 64'(3'b111));

        // All three requesting after reset: grants must rotate 1,2,3,1,2,3.
        pulse_reset();
        set_in(3'b111, 1'b1, 8'h00);
        model_reset();
        run_auto(1, 600);
        check("rr_grant_count", 64'(grants.size() >= 6), 64'(1));
        for (int k = 0; k < 6 && k < grants.size(); k++)
            check($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(k % 3));

        run_auto(2, 3000);
        check("random_progress", 64'(grants.size() > 20), 64'(1));

`ifdef ADC_ARB_TIMEOUT_EN
        set_in(3'b000, 1'b1, 8'h00);
        pulse_reset();
        set_in(3'b001, 1'b1, 8'h00);
        @(posedge clock); #1;
        check("tmo_soc", 64'(soc), 64'(1));
        repeat (TMO - 1) @(posedge clock);
        #1 check("tmo_before", {62'h0, soc, err}, {62'h0, 1'b1, 1'b0});
        @(posedge clock); #1;
        check("tmo_abort", {59'h0, soc, err, dav_n}, {59'h0, 1'b0, 1'b1, 3'b111});
        set_in(3'b011, 1'b1, 8'h00);
        @(posedge clock); #1;
        check("tmo_next_soc", 64'(soc), 64'(1));
        eoc = 1'b0;
        @(posedge clock); #1;
        set_in(3'b011, 1'b1, 8'h5A);
        @(posedge clock); #1;
        check("tmo_next_winner2", {52'h0, err, dav_n, d2}, {52'h0, 1'b1, 3'b101, 8'h5A});
        set_in(3'b001, 1'b1, 8'h5A);
        @(posedge clock); #1;
        check("tmo_next_release", 64'(dav_n), 64'(3'b111));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
